osc_phase_monitor: RTL and testbench

- Digital observer for the multi-phase clock bundle that the oscillator model drives.
- Samples Nph asynchronous clock phases on a reference clock and synchronizes them.
- Over a programmable window it measures phase-0 frequency (rising-edge count) and duty cycle (high-sample count), and checks the rising-edge order of all phases.
- Used in testbenches and in the calibration loop to close frequency/duty/phase-offset control around the oscillator.

---
 rtl/osc_phase_monitor.sv | 162 ++++++++++++++++
 tb/tb_osc_phase_monitor.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/osc_phase_monitor.sv
// osc_phase_monitor: samples Nph asynchronous clock phases on clk and
// synchronizes them. Over a WIN-cycle window it counts phase-0 rising edges
// and high samples, and flags any break in the phase rising-edge order.
module osc_phase_monitor #(
  parameter int Nph  = 4,
  parameter int WIN  = 1024,
  parameter int CW   = 16,
  parameter int SYNC = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [Nph-1:0] ck_in,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic [CW-1:0]  edge_cnt,
  output logic [CW-1:0]  high_cnt,
  output logic           order_err,
  output logic           timeout
);

  localparam int TW = $clog2(WIN);
  localparam int PW = (Nph > 1) ? $clog2(Nph) : 1;
  localparam logic [TW-1:0] TLAST   = TW'(WIN - 1);
  localparam logic [CW-1:0] CMAX    = '1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1 % Nph);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEAS, S_DONE} state_t;

  state_t         r_state, w_state_nxt;
  logic [Nph-1:0] r_sync [SYNC];
  logic [Nph-1:0] r_prev;
  logic [Nph-1:0] w_s, w_rise, w_exp;
  logic [TW-1:0]  r_timer, w_timer_nxt;
  logic [CW-1:0]  r_edge_w, w_edge_nxt, r_high_w, w_high_nxt;
  logic           r_order_w, w_order_nxt, r_tmo_w, w_tmo_nxt;
  logic [PW-1:0]  r_ptr, w_ptr_nxt, w_ptr_adv, w_idx;
  logic           w_order_bad;
  int             w_pop;

  assign w_s    = r_sync[SYNC-1];
  assign w_rise = w_s & ~r_prev;

  // Synchronizer chain and previous-sample register for edge detection.
  // NOTE: the synchronizer is an array but is still cleared on reset, so the
  // edge detector cannot see a phantom rising edge after reset is released.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < SYNC; k++) r_sync[k] <= '0;
      r_prev <= '0;
    end else begin
      r_sync[0] <= ck_in;
      for (int k = 1; k < SYNC; k++) r_sync[k] <= r_sync[k-1];
      r_prev <= w_s;
    end
  end

  // Order check: the rising phases this cycle must be the next m indices
  // starting at ptr (mod Nph); m >= Nph means the phases were undersampled.
  always_comb begin
    w_pop = 0;
    w_exp = '0;
    w_idx = '0;
    for (int i = 0; i < Nph; i++) w_pop = w_pop + int'(w_rise[i]);
    for (int k = 0; k < Nph; k++) begin
      w_idx = PW'((int'(r_ptr) + k) % Nph);
      if (k < w_pop) w_exp[w_idx] = 1'b1;
    end
    w_order_bad = (Nph > 1) && (w_pop > 0) && ((w_pop >= Nph) || (w_exp != w_rise));
    w_ptr_adv   = PW'((int'(r_ptr) + w_pop) % Nph);
  end

  // FSM state register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and working-register next values.
  // NOTE: every output of this block is given a hold default first so no
  // path through the case leaves a variable unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_edge_nxt  = r_edge_w;
    w_high_nxt  = r_high_w;
    w_order_nxt = r_order_w;
    w_tmo_nxt   = r_tmo_w;
    w_ptr_nxt   = r_ptr;
    unique case (r_state)
      S_IDLE: begin
        w_timer_nxt = '0;
        w_edge_nxt  = '0;
        w_high_nxt  = '0;
        w_order_nxt = 1'b0;
        w_tmo_nxt   = 1'b0;
        w_ptr_nxt   = '0;
        if (start) w_state_nxt = S_ARM;
      end
      S_ARM: begin
        if (w_rise[0]) begin
          // Aligning edge starts the window but is not itself counted.
          w_state_nxt = S_MEAS;
          w_timer_nxt = '0;
          w_ptr_nxt   = PTR_ONE;
        end else if (r_timer == TLAST) begin
          w_state_nxt = S_DONE;
          w_tmo_nxt   = 1'b1;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      S_MEAS: begin
        if (w_rise[0] && (r_edge_w != CMAX)) w_edge_nxt = r_edge_w + 1'b1;
        if (w_s[0] && (r_high_w != CMAX))    w_high_nxt = r_high_w + 1'b1;
        if (w_order_bad) w_order_nxt = 1'b1;
        w_ptr_nxt = w_ptr_adv;
        if (r_timer == TLAST) w_state_nxt = S_DONE;
        else                  w_timer_nxt = r_timer + 1'b1;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Working registers, registered status and result outputs. Results load
  // on entry to DONE so they change in the same cycle that done pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_timer   <= '0;
      r_edge_w  <= '0;
      r_high_w  <= '0;
      r_order_w <= 1'b0;
      r_tmo_w   <= 1'b0;
      r_ptr     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      edge_cnt  <= '0;
      high_cnt  <= '0;
      order_err <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      r_timer   <= w_timer_nxt;
      r_edge_w  <= w_edge_nxt;
      r_high_w  <= w_high_nxt;
      r_order_w <= w_order_nxt;
      r_tmo_w   <= w_tmo_nxt;
      r_ptr     <= w_ptr_nxt;
      busy      <= (w_state_nxt == S_ARM) || (w_state_nxt == S_MEAS);
      done      <= (w_state_nxt == S_DONE);
      if (w_state_nxt == S_DONE) begin
        edge_cnt  <= w_edge_nxt;
        high_cnt  <= w_high_nxt;
        order_err <= w_order_nxt;
        timeout   <= w_tmo_nxt;
      end
    end
  end

endmodule

// File: tb/tb_osc_phase_monitor.sv
// Bench for osc_phase_monitor: 1 GHz sampling clock, ~100 MHz 4-phase input,
// table-driven window scenarios plus exact small-window sequences.
`timescale 1ns/1ps
module tb_osc_phase_monitor;

  logic clk = 1'b0;
  always #0.5 clk = ~clk;

  logic        reset, start;
  logic [3:0]  ck_in;
  logic        busy, done, order_err, timeout;
  logic [15:0] edge_cnt, high_cnt;

  logic        busy_s, done_s, order_s, tmo_s;
  logic [3:0]  edge_s, high_s;

  logic [1:0]  ck_sm;
  logic        start_sm, busy_m, done_m, order_m, tmo_m;
  logic [3:0]  edge_m, high_m;

  osc_phase_monitor #(.Nph(4), .WIN(1000), .CW(16), .SYNC(2)) u_dut (
    .clk(clk), .reset(reset), .ck_in(ck_in), .start(start),
    .busy(busy), .done(done), .edge_cnt(edge_cnt), .high_cnt(high_cnt),
    .order_err(order_err), .timeout(timeout));

  osc_phase_monitor #(.Nph(4), .WIN(1000), .CW(4), .SYNC(2)) u_sat (
    .clk(clk), .reset(reset), .ck_in(ck_in), .start(start),
    .busy(busy_s), .done(done_s), .edge_cnt(edge_s), .high_cnt(high_s),
    .order_err(order_s), .timeout(tmo_s));

  osc_phase_monitor #(.Nph(2), .WIN(8), .CW(4), .SYNC(2)) u_sm (
    .clk(clk), .reset(reset), .ck_in(ck_sm), .start(start_sm),
    .busy(busy_m), .done(done_m), .edge_cnt(edge_m), .high_cnt(high_m),
    .order_err(order_m), .timeout(tmo_m));

  // Phase generator: period split into quarters, each phase owns a slot.
  // A period of 10.01 ns drifts across the 1 ns sampling grid.
  real per_ns = 10.01;
  int  duty_q = 2;
  bit  swap   = 1'b0;
  bit  gen_en = 1'b0;

  initial begin : phase_gen
    int slot;
    ck_in = '0;
    #0.3;
    forever begin
      for (int q = 0; q < 4; q++) begin
        for (int g = 0; g < 4; g++) begin
          slot = (swap && g == 1) ? 3 : (swap && g == 3) ? 1 : g;
          ck_in[g] = gen_en && (((q - slot + 4) % 4) < duty_q);
        end
        #(per_ns / 4.0);
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input logic [31:0] act, input int lo, input int hi);
    n_checks++;
    if ($isunknown(act) || act < 32'(lo) || act > 32'(hi)) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Wait for done on the main instance; counts cycles where busy dropped early.
  task automatic wait_done(input int budget, output bit seen, output int gap);
    seen = 1'b0;
    gap  = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1)      seen = 1'b1;
      else if (busy !== 1'b1) gap++;
    end
  endtask

  // Run the small instance with a 4-cycle pattern per phase (MSB first).
  task automatic sm_run(input logic [3:0] p0, input logic [3:0] p1, input bit stop,
                        output bit seen, output int cyc);
    seen = 1'b0;
    cyc  = 0;
    @(negedge clk);
    ck_sm    = 2'b00;
    start_sm = 1'b1;
    @(negedge clk);
    start_sm = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (done_m === 1'b1) begin
        seen = 1'b1;
      end else begin
        ck_sm = stop ? 2'b00 : {p1[3 - (k % 4)], p0[3 - (k % 4)]};
        cyc++;
        @(negedge clk);
      end
    end
  endtask

  typedef struct {
    int duty_q;
    bit swap;
    bit en;
    int edge_lo, edge_hi, high_lo, high_hi;
    bit exp_order, exp_tmo;
    int sat_edge, sat_high;
  } vec_t;

  vec_t vecs [4];

  initial begin : main
    bit seen;
    int gap, cyc, done_hits;

    vecs[0] = '{2, 1'b0, 1'b1, 99, 101, 490, 510, 1'b0, 1'b0, 15, 15};
    vecs[1] = '{1, 1'b0, 1'b1, 99, 101, 240, 260, 1'b0, 1'b0, 15, 15};
    vecs[2] = '{2, 1'b1, 1'b1, 99, 101, 490, 510, 1'b1, 1'b0, 15, 15};
    vecs[3] = '{2, 1'b0, 1'b0,  0,   0,   0,   0, 1'b0, 1'b1,  0,  0};

    reset = 1'b1; start = 1'b0; start_sm = 1'b0; ck_sm = 2'b00;
    repeat (4) @(negedge clk);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst edge_cnt", edge_cnt, 0);
    check("rst high_cnt", high_cnt, 0);
    check("rst order_err", order_err, 0);
    check("rst timeout", timeout, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("idle busy", busy, 0);

    for (int v = 0; v < 4; v++) begin
      duty_q = vecs[v].duty_q;
      swap   = vecs[v].swap;
      gen_en = vecs[v].en;
      repeat (30) @(negedge clk);
      check($sformatf("v%0d busy before start", v), busy, 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check($sformatf("v%0d busy after start", v), busy, 1);
      wait_done(2200, seen, gap);
      check($sformatf("v%0d done seen", v), 32'(seen), 1);
      check($sformatf("v%0d busy gap", v), gap, 0);
      check_rng($sformatf("v%0d edge_cnt", v), edge_cnt, vecs[v].edge_lo, vecs[v].edge_hi);
      check_rng($sformatf("v%0d high_cnt", v), high_cnt, vecs[v].high_lo, vecs[v].high_hi);
      check($sformatf("v%0d order_err", v), order_err, 32'(vecs[v].exp_order));
      check($sformatf("v%0d timeout", v), timeout, 32'(vecs[v].exp_tmo));
      check($sformatf("v%0d sat done", v), done_s, 1);
      check($sformatf("v%0d sat edge", v), edge_s, vecs[v].sat_edge);
      check($sformatf("v%0d sat high", v), high_s, vecs[v].sat_high);
      @(negedge clk);
      check($sformatf("v%0d done one cycle", v), done, 0);
    end

    // Results hold after DONE.
    repeat (5) @(negedge clk);
    check("hold timeout", timeout, 1);
    check("hold edge_cnt", edge_cnt, 0);

    // Reset in the middle of a measurement.
    duty_q = 2; swap = 1'b0; gen_en = 1'b1;
    repeat (30) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (510) @(negedge clk);
    check("mid busy before reset", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid busy", busy, 0);
    check("mid done", done, 0);
    check("mid edge_cnt", edge_cnt, 0);
    check("mid high_cnt", high_cnt, 0);
    check("mid order_err", order_err, 0);
    check("mid timeout", timeout, 0);
    done_hits = 0;
    for (int i = 0; i < 1600; i++) begin
      @(negedge clk);
      if (done !== 1'b0) done_hits++;
    end
    check("mid no done pulse", done_hits, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(2200, seen, gap);
    check("post done seen", 32'(seen), 1);
    check_rng("post edge_cnt", edge_cnt, 99, 101);
    check_rng("post high_cnt", high_cnt, 490, 510);
    check("post order_err", order_err, 0);
    gen_en = 1'b0;

    // Exact small-window sequences (Nph=2, WIN=8).
    sm_run(4'b1100, 4'b0110, 1'b0, seen, cyc);
    check("sm ok done", 32'(seen), 1);
    check("sm ok edge", edge_m, 2);
    check("sm ok high", high_m, 4);
    check("sm ok order", order_m, 0);
    check("sm ok timeout", tmo_m, 0);

    sm_run(4'b1100, 4'b1100, 1'b0, seen, cyc);
    check("sm undersampled done", 32'(seen), 1);
    check("sm undersampled order", order_m, 1);
    check("sm undersampled edge", edge_m, 2);
    check("sm undersampled high", high_m, 4);

    sm_run(4'b0000, 4'b0000, 1'b1, seen, cyc);
    check("sm stop done", 32'(seen), 1);
    check("sm stop arm cycles", cyc, 8);
    check("sm stop timeout", tmo_m, 1);
    check("sm stop edge", edge_m, 0);
    check("sm stop high", high_m, 0);
    check("sm stop order", order_m, 0);

    // start held high re-arms the cycle after DONE.
    ck_sm = 2'b00;
    start_sm = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done_m === 1'b1) seen = 1'b1;
    end
    check("rearm first done", 32'(seen), 1);
    @(negedge clk);
    check("rearm idle busy", busy_m, 0);
    @(negedge clk);
    check("rearm busy again", busy_m, 1);
    start_sm = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done_m === 1'b1) seen = 1'b1;
    end
    check("rearm second done", 32'(seen), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
